// File: rtl/mem_responder.sv
// mem_responder: unified 16-bit-word memory that serves fetches and data
// reads/writes with a programmable number of wait states.
// Optional feature: define ADDR_CHECK_EN to flag out-of-range addresses
// (addr_err pulse, reads return 16'hFFFF, writes suppressed).
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] pc1,
  input  logic        instr_req,
  output logic [15:0] instrout1,
  output logic        instr_valid,
  input  logic [15:0] addr1,
  input  logic [1:0]  memcontrol1,
  input  logic [15:0] dataout1,
  output logic [15:0] datain1,
  output logic        data_valid,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [15:0]           r_mem [DEPTH];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [1:0]            r_kind;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic                  r_hi_nz;
  logic [15:0]           r_instr;
  logic [15:0]           r_rdata;
  logic                  r_ivalid;
  logic                  r_dvalid;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_data_cmd;
  logic                  w_accept;
  logic [1:0]            w_req_kind;
  logic [15:0]           w_req_addr16;
  logic                  w_req_hi;
  logic                  w_enter_resp;
  logic [1:0]            w_sel_kind;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_hi;
  logic                  w_sel_err;
  logic [15:0]           w_rd_word;

  // Request decode; in IDLE the live request is used, otherwise the latched one
  // (covers the zero-wait case where the response is loaded at the accept edge).
  always_comb begin
    w_data_cmd   = (memcontrol1 == 2'b01) || (memcontrol1 == 2'b10);
    w_accept     = (r_state == ST_IDLE) && (w_data_cmd || instr_req);
    w_req_kind   = w_data_cmd ? ((memcontrol1 == 2'b10) ? K_WRITE : K_READ) : K_FETCH;
    w_req_addr16 = w_data_cmd ? addr1 : pc1;
    w_req_hi     = |(w_req_addr16 >> ADDR_WIDTH);
    w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                   ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    if (r_state == ST_IDLE) begin
      w_sel_kind = w_req_kind;
      w_sel_addr = w_req_addr16[ADDR_WIDTH-1:0];
      w_sel_hi   = w_req_hi;
    end else begin
      w_sel_kind = r_kind;
      w_sel_addr = r_addr;
      w_sel_hi   = r_hi_nz;
    end
  end

`ifdef ADDR_CHECK_EN
  assign w_sel_err = w_sel_hi;
`else
  // Upper address bits alias; the flag is computed but never acted on.
  logic w_unused_hi;
  assign w_unused_hi = w_sel_hi;
  assign w_sel_err   = 1'b0;
`endif

  assign w_rd_word = w_sel_err ? 16'hFFFF : r_mem[w_sel_addr];

  // Control FSM, request latches and registered response outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_kind   <= K_FETCH;
      r_addr   <= '0;
      r_wdata  <= 16'h0000;
      r_hi_nz  <= 1'b0;
      r_instr  <= 16'h0000;
      r_rdata  <= 16'h0000;
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_kind  <= w_req_kind;
            r_addr  <= w_req_addr16[ADDR_WIDTH-1:0];
            r_wdata <= dataout1;
            r_hi_nz <= w_req_hi;
            r_cnt   <= WAIT_INIT;
            r_busy  <= 1'b1;
            r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Response data and pulses are loaded on the edge entering RESP.
      if (w_enter_resp) begin
        r_err <= w_sel_err;
        case (w_sel_kind)
          K_FETCH: begin
            r_instr  <= w_rd_word;
            r_ivalid <= 1'b1;
          end
          K_READ: begin
            r_rdata  <= w_rd_word;
            r_dvalid <= 1'b1;
          end
          default: r_dvalid <= 1'b1;
        endcase
      end
    end
  end

  // Array write on the edge ending RESP; reset drops it, array is never cleared.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && (r_state == ST_RESP) && (r_kind == K_WRITE) && !w_sel_err) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign instrout1   = r_instr;
  assign instr_valid = r_ivalid;
  assign datain1     = r_rdata;
  assign data_valid  = r_dvalid;
  assign busy        = r_busy;
  assign addr_err    = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with one wait state and one
// with zero wait states. Honours ADDR_CHECK_EN for the out-of-range case.
module tb_mem_responder;

  logic        clk;
  logic        rst;

  logic [15:0] pc, addr, wdat, instr, rdata;
  logic [1:0]  ctl;
  logic        ireq, iv, dv, bsy, err;

  logic [15:0] pc_z, addr_z, wdat_z, instr_z, rdata_z;
  logic [1:0]  ctl_z;
  logic        ireq_z, iv_z, dv_z, bsy_z, err_z;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u_dut (
    .CLOCK_50(clk), .reset(rst),
    .pc1(pc), .instr_req(ireq), .instrout1(instr), .instr_valid(iv),
    .addr1(addr), .memcontrol1(ctl), .dataout1(wdat), .datain1(rdata),
    .data_valid(dv), .busy(bsy), .addr_err(err)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut_z (
    .CLOCK_50(clk), .reset(rst),
    .pc1(pc_z), .instr_req(ireq_z), .instrout1(instr_z), .instr_valid(iv_z),
    .addr1(addr_z), .memcontrol1(ctl_z), .dataout1(wdat_z), .datain1(rdata_z),
    .data_valid(dv_z), .busy(bsy_z), .addr_err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pc = 16'h0; ireq = 1'b0; addr = 16'h0; ctl = 2'b00; wdat = 16'h0;
    pc_z = 16'h0; ireq_z = 1'b0; addr_z = 16'h0; ctl_z = 2'b00; wdat_z = 16'h0;
    tick();
    tick();
    check("rst_instrout", instr, 16'h0000);
    check("rst_datain", rdata, 16'h0000);
    check("rst_ivalid", iv, 1'b0);
    check("rst_dvalid", dv, 1'b0);
    check("rst_busy", bsy, 1'b0);
    check("rst_addr_err", err, 1'b0);
    rst = 1'b0;

    // 1: write 1234 to addr 5
    ctl = 2'b10; addr = 16'd5; wdat = 16'h1234;
    tick();  // E0 accept
    check("wr_busy_e0", bsy, 1'b1);
    check("wr_dv_e0", dv, 1'b0);
    tick();  // E1 -> RESP
    check("wr_dv_e1", dv, 1'b1);
    check("wr_busy_e1", bsy, 1'b1);
    ctl = 2'b00;
    tick();
    check("wr_dv_e2", dv, 1'b0);
    check("wr_busy_e2", bsy, 1'b0);

    // 2: read back addr 5
    ctl = 2'b01; addr = 16'd5;
    tick();
    check("rd_dv_e0", dv, 1'b0);
    tick();
    check("rd_dv_e1", dv, 1'b1);
    check("rd_data_e1", rdata, 16'h1234);
    ctl = 2'b00;
    tick();
    check("rd_dv_e2", dv, 1'b0);
    check("rd_hold", rdata, 16'h1234);

    // 3: simultaneous fetch and read; data wins
    ireq = 1'b1; pc = 16'd5; ctl = 2'b01; addr = 16'd5;
    tick();  // E0 accepts read
    tick();  // E1
    check("pri_dv", dv, 1'b1);
    check("pri_iv_low", iv, 1'b0);
    ctl = 2'b00;
    tick();  // E2 back to IDLE
    check("pri_busy_idle", bsy, 1'b0);
    check("pri_iv_e2", iv, 1'b0);
    tick();  // E3 accepts fetch
    check("pri_busy_fetch", bsy, 1'b1);
    check("pri_iv_e3", iv, 1'b0);
    tick();  // E4
    check("pri_iv_e4", iv, 1'b1);
    check("pri_instr", instr, 16'h1234);
    ireq = 1'b0;
    tick();
    check("pri_iv_e5", iv, 1'b0);

    // 5: prime addr 7, then abort a write of BEEF with reset in WAIT
    ctl = 2'b10; addr = 16'd7; wdat = 16'h7777;
    tick();
    tick();
    ctl = 2'b00;
    tick();
    ctl = 2'b10; addr = 16'd7; wdat = 16'hBEEF;
    tick();  // accept
    check("abort_busy", bsy, 1'b1);
    rst = 1'b1;
    tick();
    check("abort_dv", dv, 1'b0);
    check("abort_busy_rst", bsy, 1'b0);
    check("abort_datain_rst", rdata, 16'h0000);
    rst = 1'b0; ctl = 2'b00;
    tick();
    check("abort_dv_after", dv, 1'b0);
    ctl = 2'b01; addr = 16'd7;
    tick();
    tick();
    check("abort_rd_dv", dv, 1'b1);
    check("abort_rd_data", rdata, 16'h7777);
    ctl = 2'b00;
    tick();

    // 6: out-of-range read 0x0105
    ctl = 2'b01; addr = 16'h0105;
    tick();
    tick();
    check("oor_dv", dv, 1'b1);
`ifdef ADDR_CHECK_EN
    check("oor_data", rdata, 16'hFFFF);
    check("oor_err", err, 1'b1);
`else
    check("oor_data", rdata, 16'h1234);
    check("oor_err", err, 1'b0);
`endif
    ctl = 2'b00;
    tick();
    check("oor_err_clear", err, 1'b0);

    // 4: zero wait states; preload words 0 and 1, then back-to-back fetches
    ctl_z = 2'b10; addr_z = 16'd0; wdat_z = 16'hA000;
    tick();
    check("z_wr0_dv", dv_z, 1'b1);
    ctl_z = 2'b00;
    tick();
    check("z_wr0_dv_end", dv_z, 1'b0);
    ctl_z = 2'b10; addr_z = 16'd1; wdat_z = 16'hA001;
    tick();
    ctl_z = 2'b00;
    tick();
    ireq_z = 1'b1; pc_z = 16'd0;
    tick();
    check("z_f0_iv", iv_z, 1'b1);
    check("z_f0_instr", instr_z, 16'hA000);
    pc_z = 16'd1;
    tick();
    check("z_gap_iv", iv_z, 1'b0);
    check("z_gap_busy", bsy_z, 1'b0);
    tick();
    check("z_f1_iv", iv_z, 1'b1);
    check("z_f1_instr", instr_z, 16'hA001);
    ireq_z = 1'b0;
    tick();
    check("z_end_iv", iv_z, 1'b0);
    check("z_hold_instr", instr_z, 16'hA001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
